// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, majority-vote offset and parameter limits for uart_rx_fifo
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

    localparam int MAJ_OFFSET     = 1;
    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 4;
    localparam int OVERSAMPLE_MAX = 16;
    localparam int FIFO_DEPTH_MIN = 2;
    localparam int FIFO_DEPTH_MAX = 64;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through FIFO with registered head and simultaneous push/pop
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && cnt_q != '0;
    assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH) || do_pop);

    // Next pointers/occupancy; head register takes the incoming word when it lands in an empty FIFO
    always_comb begin
        wptr_d = wptr_q + AW'(do_push);
        rptr_d = rptr_q + AW'(do_pop);
        cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout_d = dout_q;
        if (cnt_d != '0) dout_d = (cnt_q == (AW+1)'(do_pop)) ? wdata_i : mem_q[rptr_d];
    end

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    // Pointer, count and head state
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign rdata_o = dout_q;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign level_o = cnt_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with break detection and FWFT receive FIFO; define UART_RX_PARITY_EN for parity checking
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_clk,
    input  logic                          rxd,
    input  logic                          rd,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    output logic                          break_det,
    input  logic                          clr_err
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int W  = DATA_BITS + 2;

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("DATA_BITS out of range");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || OVERSAMPLE % 2 != 0) begin : g_bad_oversample
        $error("OVERSAMPLE must be even and in range");
    end
    if (FIFO_DEPTH < FIFO_DEPTH_MIN || FIFO_DEPTH > FIFO_DEPTH_MAX || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 in range");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("PARITY_ODD must be 0 or 1");
    end

    state_e               state_q, state_d;
    logic                 sync_q, rxs_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [3:0]           bit_q, bit_d;
    logic                 ferr_q, ferr_d, brk_q, brk_d, ovr_q;
    logic                 push, dec, at_dec, ferr_n, perr;
    logic [W-1:0]         head;

    assign dec    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);
    assign at_dec = rx_clk && cnt_q == CW'(M + MAJ_OFFSET);
    assign ferr_n = ferr_q | ~dec;

`ifdef UART_RX_PARITY_EN
    localparam state_e AFTER_DATA = PARITY;
    logic par_q;
    assign perr = ^{data_q, par_q} ^ (PARITY_ODD != 0);

    // Parity bit captured at its decision point
    always_ff @(posedge clk) begin
        if (reset) par_q <= 1'b0;
        else if (state_q == PARITY && at_dec) par_q <= dec;
    end
`else
    localparam state_e AFTER_DATA = STOP;
    assign perr = 1'b0;
`endif

    // Two-flop synchroniser; idles high so reset does not fake a start bit
    always_ff @(posedge clk) begin
        if (reset) {sync_q, rxs_q} <= 2'b11;
        else {sync_q, rxs_q} <= {rxd, sync_q};
    end

    // Bit timing, majority vote and frame sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vote_d  = vote_q;
        data_d  = data_q;
        bit_d   = bit_q;
        ferr_d  = ferr_q;
        brk_d   = 1'b0;
        push    = 1'b0;
        if (rx_clk) begin
            cnt_d = (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CW'(M - MAJ_OFFSET)) vote_d[0] = rxs_q;
            if (cnt_q == CW'(M)) vote_d[1] = rxs_q;
        end
        case (state_q)
            IDLE: if (!rxs_q) begin
                state_d = START;
                cnt_d   = '0;
                bit_d   = '0;
                ferr_d  = 1'b0;
            end
            START: if (at_dec) state_d = dec ? IDLE : DATA;
            DATA: if (at_dec) begin
                data_d = {dec, data_q[DATA_BITS-1:1]};
                bit_d  = (bit_q == 4'(DATA_BITS - 1)) ? '0 : bit_q + 1'b1;
                if (bit_q == 4'(DATA_BITS - 1)) state_d = AFTER_DATA;
            end
            PARITY: if (at_dec) state_d = STOP;
            STOP: if (at_dec) begin
                ferr_d = ferr_n;
                bit_d  = bit_q + 1'b1;
                if (bit_q == 4'(STOP_BITS - 1)) begin
                    brk_d   = data_q == '0 && ferr_n;
                    push    = !brk_d;
                    state_d = ferr_n ? WAIT_HIGH : IDLE;
                end
            end
            WAIT_HIGH: if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vote_q  <= '0;
            data_q  <= '0;
            bit_q   <= '0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vote_q  <= vote_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

    // Sticky overrun: a push that finds the FIFO full with no pop; set beats clear
    always_ff @(posedge clk) begin
        if (reset) ovr_q <= 1'b0;
        else ovr_q <= (push & full & ~rd) | (ovr_q & ~clr_err);
    end

    uart_sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i ({ferr_n, perr, data_q}),
        .pop_i   (rd),
        .rdata_o (head),
        .empty_o (empty),
        .full_o  (full),
        .level_o (level)
    );

    assign {rd_frame_err, rd_parity_err, rd_data} = head;
    assign overrun   = ovr_q;
    assign break_det = brk_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: random and directed frames against a queue-based model of the receiver
module tb_uart_rx_fifo;

    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int DEPTH    = 4;
    localparam int PODD     = 0;
    localparam int BIT_CLKS = OS * 4;

    typedef struct {
        logic [DB-1:0] data;
        bit            ferr;
        bit            perr;
    } word_t;

    logic                    clk = 0, reset = 1, rx_clk = 0, rxd = 1, rd = 0, clr_err = 0;
    logic [DB-1:0]           rd_data;
    logic                    rd_frame_err, rd_parity_err, empty, full, overrun, break_det;
    logic [$clog2(DEPTH):0]  level;

    int    checks = 0, errors = 0;
    word_t q[$];
    word_t last;
    bit    exp_ovr = 0;
    int    exp_brk = 0, brk_pulses = 0, brk_high = 0;

    uart_rx_fifo #(
        .DATA_BITS  (DB),
        .STOP_BITS  (1),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH),
        .PARITY_ODD (PODD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_clk        (rx_clk),
        .rxd           (rxd),
        .rd            (rd),
        .rd_data       (rd_data),
        .rd_frame_err  (rd_frame_err),
        .rd_parity_err (rd_parity_err),
        .empty         (empty),
        .full          (full),
        .level         (level),
        .overrun       (overrun),
        .break_det     (break_det),
        .clr_err       (clr_err)
    );

    always #5 clk = ~clk;

    initial begin : strobe
        int ph = 0;
        forever begin
            @(negedge clk);
            rx_clk = (ph == 0);
            ph = (ph + 1) % 4;
        end
    end

    initial begin : brk_mon
        logic prev = 0;
        forever begin
            @(negedge clk);
            if (break_det) brk_high++;
            if (break_det && !prev) brk_pulses++;
            prev = break_det;
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit good_par(logic [DB-1:0] d);
        return bit'(($countones(d) + PODD) % 2);
    endfunction

    task automatic check_state(string tag);
        if (q.size() > 0) last = q[0];
        check({tag, ".level"}, 32'(level), q.size());
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
        check({tag, ".brk_pulses"}, brk_pulses, exp_brk);
        check({tag, ".brk_high"}, brk_high, exp_brk);
        check({tag, ".data"}, 32'(rd_data), 32'(last.data));
        check({tag, ".ferr"}, 32'(rd_frame_err), 32'(last.ferr));
        check({tag, ".perr"}, 32'(rd_parity_err), 32'(last.perr));
    endtask

    task automatic send_bit(bit v);
        rxd = v;
        tick(BIT_CLKS);
    endtask

    task automatic send_frame(logic [DB-1:0] d, bit pbit, bit stop);
        word_t w;
        send_bit(0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(pbit);
        w.perr = (($countones(d) + pbit) % 2) != PODD;
`else
        w.perr = pbit & 1'b0;
`endif
        send_bit(stop);
        send_bit(1);
        w.data = d;
        w.ferr = !stop;
        if (d == 0 && !stop) exp_brk++;
        else if (q.size() == DEPTH) exp_ovr = 1;
        else q.push_back(w);
    endtask

    task automatic pop_word(string tag);
        rd = 1;
        tick(1);
        rd = 0;
        if (q.size() > 0) void'(q.pop_front());
        check_state(tag);
    endtask

    task automatic clear_err(string tag);
        clr_err = 1;
        tick(1);
        clr_err = 0;
        exp_ovr = 0;
        check_state(tag);
    endtask

    initial begin
        logic [DB-1:0] d;
        bit stop, pb;
        last = '{data: '0, ferr: 0, perr: 0};
        tick(4);
        reset = 0;
        tick(2);
        check_state("reset");

        send_frame(8'h55, good_par(8'h55), 1);
        send_frame(8'hA3, good_par(8'hA3), 1);
        check_state("two_frames");
        pop_word("pop_55");
        pop_word("pop_a3");
        pop_word("pop_empty");

        rxd = 0;
        tick($urandom_range(8, 24));
        rxd = 1;
        tick(2 * BIT_CLKS);
        check_state("glitch");

        for (int i = 0; i < DEPTH + 1; i++) begin
            send_frame(8'(i * 17 + 3), good_par(8'(i * 17 + 3)), 1);
            check_state("fill");
        end
        clear_err("clr_err");
        for (int i = 0; i < DEPTH; i++) pop_word("drain");

        send_frame(8'h3C, good_par(8'h3C), 0);
        check_state("frame_err");
        pop_word("pop_3c");

        rxd = 0;
        tick(25 * BIT_CLKS);
        exp_brk++;
        check_state("break_low");
        rxd = 1;
        tick(2 * BIT_CLKS);
        send_frame(8'h81, good_par(8'h81), 1);
        check_state("after_break");
        pop_word("pop_81");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 0, 1);
        send_frame(8'h07, 1, 1);
        check_state("par_bad");
        pop_word("par_good");
        pop_word("par_drain");
`endif

        send_frame(8'h5A, good_par(8'h5A), 1);
        send_bit(0);
        for (int i = 0; i < 3; i++) send_bit(1'(i));
        reset = 1;
        rxd = 1;
        tick(2);
        reset = 0;
        q.delete();
        exp_ovr = 0;
        last = '{data: '0, ferr: 0, perr: 0};
        tick(2 * BIT_CLKS);
        check_state("mid_reset");

        for (int n = 0; n < 20; n++) begin
            d = ($urandom_range(0, 5) == 0) ? '0 : DB'($urandom);
            stop = $urandom_range(0, 5) != 0;
            pb = ($urandom_range(0, 3) == 0) ? !good_par(d) : good_par(d);
            send_frame(d, pb, stop);
            check_state("rand_frame");
            for (int k = $urandom_range(0, 2); k > 0; k--) pop_word("rand_pop");
            if (exp_ovr && $urandom_range(0, 1) == 1) clear_err("rand_clr");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
